// File: rtl/seq_div8_if.sv
// seq_div8_if: valid/ready request and result channels of the sequential divider.
interface seq_div8_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic [2*N-1:0] a;
  logic [N-1:0]   b;
  logic         out_valid;
  logic         out_ready;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic         dz;
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, dz
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, dz
  );
endinterface

// File: rtl/seq_div8.sv
// seq_div8: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module seq_div8 #(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div8_if.slave bus
);
  localparam int CW = $clog2(2 * N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q;
  logic           in_ready_q, out_valid_q, dz_q;
  logic [2*N-1:0] dvd_q, quo_q;
  logic [N-1:0]   dvs_q, pr_q;
  logic [CW-1:0]  cnt_q;
  logic [N:0]     sh_d;
  logic [N-1:0]   diff_d, pr_d;
  logic           qbit_d;
  logic [2*N-1:0] quo_d;
  // Partial remainder stays below the divisor, so N bits hold it after each step.
  always_comb begin
    sh_d   = {pr_q, dvd_q[2*N-1]};
    qbit_d = sh_d >= {1'b0, dvs_q};
    diff_d = sh_d[N-1:0] - dvs_q;
    pr_d   = qbit_d ? diff_d : sh_d[N-1:0];
    quo_d  = {quo_q[2*N-2:0], qbit_d};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_q    <= RUN;
          in_ready_q <= 1'b0;
          dvd_q      <= bus.a;
          dvs_q      <= bus.b;
          pr_q       <= '0;
          quo_q      <= '0;
          cnt_q      <= CW'(2 * N);
          dz_q       <= bus.b == '0;
        end
        RUN: begin
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - 1'b1;
          quo_q <= quo_d;
          pr_q  <= pr_d;
          // Last step: a zero divisor still runs full length, then the result is forced.
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= dz_q ? '1 : quo_d;
            pr_q        <= dz_q ? '0 : pr_d;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = quo_q;
  assign bus.r         = pr_q;
  assign bus.dz        = dz_q;
endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: directed and randomised checks of seq_div8 against hand-computed quotients.
module tb_seq_div8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0, n_err = 0, n_acc = 0, n_res = 0;
  seq_div8_if #(.N(N)) bus ();
  seq_div8 #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) n_acc++;
    if (rst_n && bus.out_valid && bus.out_ready) n_res++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] a, input logic [3:0] b);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      step();
      k++;
    end
    chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    step();
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask
  task automatic op(input logic [7:0] a, input logic [3:0] b,
                    input logic [7:0] eq, input logic [3:0] er, input logic edz);
    int lat;
    bus.out_ready = 1'b1;
    send(a, b);
    wait_done(lat);
    chk("latency", 32'(lat), 32'd8);
    chk("q", 32'(bus.q), 32'(eq));
    chk("r", 32'(bus.r), 32'(er));
    chk("dz", 32'(bus.dz), 32'(edz));
    chk("busy_in_done", 32'(bus.in_ready), 32'd0);
    step();
    chk("consumed", 32'(bus.out_valid), 32'd0);
    chk("idle_again", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    int lat, acc0, res0;
    logic [7:0] ra, qq;
    logic [3:0] rb, rr;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_r", 32'(bus.r), 32'd0);
    chk("rst_dz", 32'(bus.dz), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    op(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    op(8'd0, 4'd7, 8'd0, 4'd0, 1'b0);
    op(8'd14, 4'd15, 8'd0, 4'd14, 1'b0);
    op(8'd99, 4'd0, 8'd255, 4'd0, 1'b1);
    // Backpressure: result must hold while a competing request is ignored.
    bus.out_ready = 1'b0;
    acc0 = n_acc;
    send(8'd100, 4'd9);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'd50;
      bus.b = 4'd3;
      step();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_q", 32'(bus.q), 32'd11);
      chk("bp_r", 32'(bus.r), 32'd1);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_consumed", 32'(bus.out_valid), 32'd0);
    chk("bp_idle", 32'(bus.in_ready), 32'd1);
    chk("bp_accepts", 32'(n_acc - acc0), 32'd1);
    // Reset in the middle of a division.
    send(8'd77, 4'd5);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_q", 32'(bus.q), 32'd0);
    chk("mid_rst_r", 32'(bus.r), 32'd0);
    step();
    step();
    #1 rst_n = 1'b1;
    step();
    op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
    acc0 = n_acc;
    res0 = n_res;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(1, 15));
      bus.out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step();
      send(ra, rb);
      wait_done(lat);
      chk("rnd_latency", 32'(lat), 32'd8);
      qq = bus.q;
      rr = bus.r;
      chk("rnd_q", 32'(qq), 32'(ra / 8'(rb)));
      chk("rnd_inv", 32'(qq) * 32'(rb) + 32'(rr), 32'(ra));
      chk("rnd_rlt", 32'(rr < rb), 32'd1);
      chk("rnd_dz", 32'(bus.dz), 32'd0);
      if (!bus.out_ready) begin
        repeat ($urandom_range(0, 3)) step();
        bus.out_ready = 1'b1;
      end
      step();
      chk("rnd_consumed", 32'(bus.out_valid), 32'd0);
    end
    chk("rnd_count", 32'(n_res - res0), 32'(n_acc - acc0));
    chk("rnd_accepts", 32'(n_acc - acc0), 32'd1000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
